// File: rtl/mult_datapath.sv
// Datapath half of the sequential 8x8 multiplier: operand latches, step counter,
// one nibble partial product per cycle, shifted and accumulated into the product.
module mult_datapath #(
  parameter int OP_W = 8
) (
  input  logic              clk,
  input  logic              reset_a,
  input  logic              start,
  input  logic [OP_W-1:0]   dataa,
  input  logic [OP_W-1:0]   datab,
  input  logic [1:0]        input_sel,
  input  logic [1:0]        shift_sel,
  input  logic              clk_ena,
  input  logic              sclr_n,
  output logic [1:0]        count,
  output logic [OP_W-1:0]   partial,
  output logic [2*OP_W-1:0] product
);

  localparam int NIB = OP_W / 2;
  localparam int PW  = 2 * OP_W;

  logic [OP_W-1:0] a_reg;
  logic [OP_W-1:0] b_reg;
  logic [NIB-1:0]  nib_a;
  logic [NIB-1:0]  nib_b;
  logic [PW-1:0]   extended;
  logic [PW-1:0]   shifted;

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (start) begin
      a_reg <= dataa;
      b_reg <= datab;
    end
  end

  // A start edge restarts the step count; otherwise it free-runs and wraps.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      count <= 2'd0;
    end else if (start) begin
      count <= 2'd0;
    end else begin
      count <= count + 2'd1;
    end
  end

  always_comb begin
    nib_a    = input_sel[1] ? a_reg[OP_W-1:NIB] : a_reg[NIB-1:0];
    nib_b    = input_sel[0] ? b_reg[OP_W-1:NIB] : b_reg[NIB-1:0];
    partial  = {{NIB{1'b0}}, nib_a} * {{NIB{1'b0}}, nib_b};
    extended = {{OP_W{1'b0}}, partial};
    shifted  = extended;
    case (shift_sel)
      2'b01:   shifted = extended << NIB;
      2'b10:   shifted = extended << OP_W;
      default: shifted = extended;
    endcase
  end

  // Clear wins over accumulate; start alone never touches the accumulator.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      product <= '0;
    end else if (!sclr_n) begin
      product <= '0;
    end else if (clk_ena) begin
      product <= product + shifted;
    end
  end

endmodule
